// File: rtl/div_pkg.sv
// Shared encodings and sizing helpers for the restoring divider sequencer.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Step counter must hold the value nBit itself.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Operand/result handshake bundle between a requester and div_sequencer.
interface div_sequencer_if #(
    parameter int unsigned nBit = 16
);
    logic            start;
    logic [nBit-1:0] dividend;
    logic [nBit-1:0] divisor;
    logic            busy;
    logic            done;
    logic [nBit-1:0] quotient;
    logic [nBit-1:0] remainder;
    logic            div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D, keep or restore.
module div_step #(
    parameter int unsigned nBit = 16
) (
    input  logic [nBit:0]   r,
    input  logic [nBit-1:0] q,
    input  logic [nBit-1:0] d,
    output logic [nBit:0]   r_next,
    output logic [nBit-1:0] q_next
);

    logic [nBit:0]   r_sh;
    logic [nBit-1:0] q_sh;
    logic [nBit:0]   trial;

    always_comb begin
        {r_sh, q_sh} = {r, q} << 1;
        trial        = r_sh - {1'b0, d};
        if (!trial[nBit]) begin
            r_next = trial;
            q_next = {q_sh[nBit-1:1], 1'b1};
        end else begin
            r_next = r_sh;
            q_next = {q_sh[nBit-1:1], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Iterative restoring divider sequencer, falling-edge clocked, one step per cycle.
// Define DIV_ZERO_CHECK_EN to short-circuit a zero divisor straight to DONE.
module div_sequencer
    import div_pkg::*;
#(
    parameter int unsigned nBit = 16
) (
    input logic            clk,
    input logic            clr_n,
    div_sequencer_if.slave bus
);

    localparam int unsigned CW = cnt_width(nBit);

    div_state_t      state, state_nx;
    logic [nBit:0]   r_q, r_nx;
    logic [nBit-1:0] q_q, q_nx;
    logic [nBit-1:0] d_q, d_nx;
    logic [CW-1:0]   cnt_q, cnt_nx;
    logic [nBit-1:0] quo_q, quo_nx;
    logic [nBit-1:0] rem_q, rem_nx;
    logic            dz_q, dz_nx;
    logic            done_q, done_nx;
    logic            busy_q, busy_nx;

    logic [nBit:0]   step_r;
    logic [nBit-1:0] step_q;

    div_step #(.nBit(nBit)) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (step_r),
        .q_next (step_q)
    );

    // State and datapath registers, updated on the downstream shift-register edge.
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            r_q    <= r_nx;
            q_q    <= q_nx;
            d_q    <= d_nx;
            cnt_q  <= cnt_nx;
            quo_q  <= quo_nx;
            rem_q  <= rem_nx;
            dz_q   <= dz_nx;
            done_q <= done_nx;
            busy_q <= busy_nx;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_nx = state;
        r_nx     = r_q;
        q_nx     = q_q;
        d_nx     = d_q;
        cnt_nx   = cnt_q;
        quo_nx   = quo_q;
        rem_nx   = rem_q;
        dz_nx    = dz_q;
        done_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    q_nx     = bus.dividend;
                    d_nx     = bus.divisor;
                    r_nx     = '0;
                    cnt_nx   = CW'(nBit);
                    quo_nx   = '0;
                    rem_nx   = '0;
                    dz_nx    = 1'b0;
                    state_nx = RUN;
`ifdef DIV_ZERO_CHECK_EN
                    // Preload the zero-divisor answer; one dwell cycle in DONE keeps latency at 2.
                    if (bus.divisor == '0) begin
                        r_nx     = {1'b0, bus.dividend};
                        q_nx     = '1;
                        cnt_nx   = CW'(1);
                        state_nx = DONE;
                    end
`endif
                end
            end
            RUN: begin
                r_nx   = step_r;
                q_nx   = step_q;
                cnt_nx = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (cnt_q != '0) begin
                    cnt_nx = cnt_q - CW'(1);
                end else begin
                    quo_nx   = q_q;
                    rem_nx   = r_q[nBit-1:0];
                    done_nx  = 1'b1;
                    state_nx = IDLE;
`ifdef DIV_ZERO_CHECK_EN
                    dz_nx    = (d_q == '0);
`endif
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
`ifdef DIV_ZERO_CHECK_EN
    assign bus.div_zero  = dz_q;
`else
    assign bus.div_zero  = 1'b0;
`endif

endmodule
